// File: rtl/cpu_core_pkg.sv
// Shared decode types for cpu_core: ALU opcodes, shift types, condition codes
// and instruction-class constants, plus small decode helpers.
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  // Instruction class taken from inst[27:26]
  localparam logic [1:0] CLS_DP = 2'b00;
  localparam logic [1:0] CLS_LS = 2'b01;
  localparam logic [1:0] CLS_BR = 2'b10;
  localparam logic [1:0] CLS_CP = 2'b11;

  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    case (alu_op_e'(op))
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ORR,
      OP_MOV, OP_BIC, OP_MVN, OP_CMP, OP_TST: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, ok;
    {n, z, c, v} = f;
    case (cond_e'(cc))
      CC_EQ: ok = z;
      CC_NE: ok = ~z;
      CC_CS: ok = c;
      CC_CC: ok = ~c;
      CC_MI: ok = n;
      CC_PL: ok = ~n;
      CC_VS: ok = v;
      CC_VC: ok = ~v;
      CC_HI: ok = c & ~z;
      CC_LS: ok = ~c | z;
      CC_GE: ok = (n == v);
      CC_LT: ok = (n != v);
      CC_GT: ok = ~z & (n == v);
      CC_LE: ok = z | (n != v);
      CC_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// 32-bit ALU for cpu_core: result plus NZCV. cin/vin carry the flag values
// kept by logical ops (shifter carry-out and current V).
module cpu_core_alu
  import cpu_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic        cin,
  input  logic        vin,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  logic [32:0] sum;
  logic        c, v;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = cin;
    v      = vin;
    case (alu_op_e'(op))
      OP_AND, OP_TST: result = a & b;
      OP_EOR:         result = a ^ b;
      OP_ORR:         result = a | b;
      OP_MOV:         result = b;
      OP_BIC:         result = a & ~b;
      OP_MVN:         result = ~b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[31:0];
        c      = sum[32];
        v      = (a[31] == b[31]) && (result[31] != a[31]);
      end
      OP_SUB, OP_CMP: begin
        // C is NOT borrow
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[31:0];
        c      = ~sum[32];
        v      = (a[31] != b[31]) && (result[31] != a[31]);
      end
      OP_RSB: begin
        sum    = {1'b0, b} - {1'b0, a};
        result = sum[31:0];
        c      = ~sum[32];
        v      = (b[31] != a[31]) && (result[31] != b[31]);
      end
      default: result = '0;
    endcase
    nzcv = {result[31], (result == 32'd0), c, v};
  end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle A32 subset core: data-processing, LDR/STR word, B/BL.
// Optional macro CPU_CORE_COND_EXEC_EN enables cond-field evaluation.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] PC
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [31:0] regs [0:14];
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic [3:0]  nzcv;

  logic [1:0]  cls;
  logic [3:0]  op, rn, rd, rm, rb;
  logic        i_bit, s_bit, is_test, dp_valid, ls_valid, exec;
  logic [31:0] rdata_a, rdata_b, op2, alu_res, mem_addr, mem_rdata, br_off;
  logic [3:0]  alu_nzcv;
  logic        sh_c;
  logic [AW-1:0] mem_idx;

  logic [31:0] pc_next, reg_wdata;
  logic [3:0]  reg_waddr;
  logic        reg_we, mem_we, flags_we;

  assign cls   = inst[27:26];
  assign i_bit = inst[25];
  assign op    = inst[24:21];
  assign s_bit = inst[20];
  assign rn    = inst[19:16];
  assign rd    = inst[15:12];
  assign rm    = inst[3:0];
  assign rb    = (cls == CLS_LS) ? rd : rm;

  // R15 is not stored; reads see the architectural PC+8
  assign rdata_a = (rn == 4'd15) ? PC + 32'd8 : regs[rn];
  assign rdata_b = (rb == 4'd15) ? PC + 32'd8 : regs[rb];

`ifdef CPU_CORE_COND_EXEC_EN
  assign exec = cond_pass(inst[31:28], nzcv);
`else
  logic cond_unused;
  assign exec        = 1'b1;
  assign cond_unused = ^{inst[31:28], nzcv[3:2]};
`endif

  // Operand2: rotated immediate or immediate-shifted Rm, with shifter carry
  always_comb begin
    logic [32:0] t;
    logic [31:0] imm32;
    logic [4:0]  amt;
    t     = '0;
    imm32 = {24'd0, inst[7:0]};
    amt   = inst[11:7];
    op2   = '0;
    sh_c  = nzcv[1];
    if (i_bit) begin
      amt = {inst[11:8], 1'b0};
      op2 = (imm32 >> amt) | (imm32 << (6'd32 - {1'b0, amt}));
      if (amt != 5'd0) sh_c = op2[31];
    end else begin
      case (shift_e'(inst[6:5]))
        SH_LSL: begin
          t   = {1'b0, rdata_b} << amt;
          op2 = t[31:0];
          if (amt != 5'd0) sh_c = t[32];
        end
        SH_LSR: begin
          if (amt == 5'd0) begin
            op2  = '0;
            sh_c = rdata_b[31];
          end else begin
            t    = {rdata_b, 1'b0} >> amt;
            op2  = t[32:1];
            sh_c = t[0];
          end
        end
        SH_ASR: begin
          if (amt == 5'd0) begin
            op2  = {32{rdata_b[31]}};
            sh_c = rdata_b[31];
          end else begin
            t    = 33'($signed({rdata_b, 1'b0}) >>> amt);
            op2  = t[32:1];
            sh_c = t[0];
          end
        end
        default: begin
          if (amt == 5'd0) begin
            op2  = {nzcv[1], rdata_b[31:1]};
            sh_c = rdata_b[0];
          end else begin
            op2  = (rdata_b >> amt) | (rdata_b << (6'd32 - {1'b0, amt}));
            sh_c = op2[31];
          end
        end
      endcase
    end
  end

  cpu_core_alu u_alu (
    .a      (rdata_a),
    .b      (op2),
    .op     (op),
    .cin    (sh_c),
    .vin    (nzcv[0]),
    .result (alu_res),
    .nzcv   (alu_nzcv)
  );

  assign is_test  = (alu_op_e'(op) == OP_TST) || (alu_op_e'(op) == OP_CMP);
  assign dp_valid = op_supported(op) && (i_bit || !inst[4]) && (!is_test || s_bit);
  assign ls_valid = !inst[25] && inst[24] && !inst[22] && !inst[21];

  assign mem_addr  = inst[23] ? rdata_a + {20'd0, inst[11:0]}
                              : rdata_a - {20'd0, inst[11:0]};
  assign mem_idx   = AW'(mem_addr >> 2);
  assign mem_rdata = dmem[mem_idx];
  assign br_off    = {{6{inst[23]}}, inst[23:0], 2'b00};

  always_comb begin
    pc_next   = PC + 32'd4;
    reg_we    = 1'b0;
    reg_waddr = rd;
    reg_wdata = alu_res;
    mem_we    = 1'b0;
    flags_we  = 1'b0;
    if (exec) begin
      case (cls)
        CLS_DP: if (dp_valid) begin
          reg_we   = !is_test;
          flags_we = s_bit;
        end
        CLS_LS: if (ls_valid) begin
          if (inst[20]) begin
            reg_we    = 1'b1;
            reg_wdata = mem_rdata;
          end else begin
            mem_we = 1'b1;
          end
        end
        CLS_BR: if (inst[25]) begin
          pc_next = PC + 32'd8 + br_off;
          if (inst[24]) begin
            reg_we    = 1'b1;
            reg_waddr = 4'd14;
            reg_wdata = PC + 32'd4;
          end
        end
        default: ;
      endcase
    end
    if (reg_waddr == 4'd15) reg_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC   <= '0;
      nzcv <= '0;
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      PC <= pc_next;
      if (flags_we) nzcv <= alu_nzcv;
      if (reg_we) regs[reg_waddr] <= reg_wdata;
    end
  end

  // Data memory has no reset; rst only blocks the pending store
  always_ff @(posedge clk) begin
    if (mem_we && !rst) dmem[mem_idx] <= rdata_b;
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core.
module tb_cpu_core;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = NOP;
  logic [31:0] PC;
  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  cpu_core #(.DMEM_WORDS(1024)) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .PC   (PC)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks passed %0d of %0d", passed, checks);
    $fatal(1);
  end

  task automatic step(input logic [31:0] i);
    inst = i;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b1;
    inst = NOP;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic allz;
    inst = 32'hE3A02007;
    @(posedge clk); #1;
    checks++;
    if (PC !== 32'd0) $display("FAIL reset_pc got %h want %h", PC, 32'd0); else passed++;
    allz = 1'b1;
    for (int i = 0; i < 15; i++) if (dut.regs[i] !== 32'd0) allz = 1'b0;
    checks++;
    if (allz !== 1'b1) $display("FAIL reset_regs got nonzero want all zero"); else passed++;
    checks++;
    if (dut.nzcv !== 4'b0000) $display("FAIL reset_flags got %b want %b", dut.nzcv, 4'b0000); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (PC !== 32'd4) $display("FAIL first_pc got %h want %h", PC, 32'd4); else passed++;
    checks++;
    if (dut.regs[2] !== 32'd7) $display("FAIL first_r2 got %h want %h", dut.regs[2], 32'd7); else passed++;
    // asynchronous assertion, sampled before any clock edge
    inst = NOP;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (PC !== 32'd0 || dut.regs[2] !== 32'd0)
      $display("FAIL async_reset got pc=%h r2=%h want pc=0 r2=0", PC, dut.regs[2]);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dp();
    step(32'hE3A02007);
    step(32'hE1A03002);
    step(32'hE0825003);
    checks++;
    if (dut.regs[3] !== 32'd7) $display("FAIL mov_reg got %h want %h", dut.regs[3], 32'd7); else passed++;
    checks++;
    if (dut.regs[5] !== 32'd14) $display("FAIL add_reg got %h want %h", dut.regs[5], 32'd14); else passed++;
    checks++;
    if (PC !== 32'hC) $display("FAIL dp_pc got %h want %h", PC, 32'hC); else passed++;
    step(32'hE2488004);
    checks++;
    if (dut.regs[8] !== 32'hFFFFFFFC) $display("FAIL sub_wrap got %h want %h", dut.regs[8], 32'hFFFFFFFC); else passed++;
    checks++;
    if (dut.nzcv !== 4'b0000) $display("FAIL sub_noflags got %b want %b", dut.nzcv, 4'b0000); else passed++;
  endtask

  task automatic test_shift();
    step(32'hE1A07202);
    checks++;
    if (dut.regs[7] !== 32'h70) $display("FAIL lsl4 got %h want %h", dut.regs[7], 32'h70); else passed++;
    step(32'hE1A070C8);
    checks++;
    if (dut.regs[7] !== 32'hFFFFFFFE) $display("FAIL asr1 got %h want %h", dut.regs[7], 32'hFFFFFFFE); else passed++;
    step(32'hE1A07312);
    step(32'hE0A77002);
    checks++;
    if (dut.regs[7] !== 32'hFFFFFFFE) $display("FAIL nop_ops got %h want %h", dut.regs[7], 32'hFFFFFFFE); else passed++;
    checks++;
    if (PC !== 32'h20) $display("FAIL shift_pc got %h want %h", PC, 32'h20); else passed++;
  endtask

  task automatic test_r15();
    step(32'hE28F6000);
    checks++;
    if (dut.regs[6] !== 32'h28) $display("FAIL read_r15 got %h want %h", dut.regs[6], 32'h28); else passed++;
    step(32'hE3A0F000);
    checks++;
    if (PC !== 32'h28) $display("FAIL write_r15 got %h want %h", PC, 32'h28); else passed++;
  endtask

  task automatic test_ldr_str();
    step(32'hE5813A01);
    step(32'hE591AA01);
    checks++;
    if (dut.dmem[10'h280] !== 32'd7) $display("FAIL str_word got %h want %h", dut.dmem[10'h280], 32'd7); else passed++;
    checks++;
    if (dut.regs[10] !== 32'd7) $display("FAIL ldr_word got %h want %h", dut.regs[10], 32'd7); else passed++;
    step(32'hE50A5003);
    checks++;
    if (dut.dmem[1] !== 32'd14) $display("FAIL str_sub got %h want %h", dut.dmem[1], 32'd14); else passed++;
    step(32'hE5D1BA01);
    checks++;
    if (dut.regs[11] !== 32'd0) $display("FAIL ldrb_nop got %h want %h", dut.regs[11], 32'd0); else passed++;
    checks++;
    if (PC !== 32'h38) $display("FAIL ls_pc got %h want %h", PC, 32'h38); else passed++;
  endtask

  task automatic test_flags();
    step(32'hE3A00102);
    checks++;
    if (dut.regs[0] !== 32'h80000000) $display("FAIL rot_imm got %h want %h", dut.regs[0], 32'h80000000); else passed++;
    step(32'hE0901000);
    checks++;
    if (dut.regs[1] !== 32'd0 || dut.nzcv !== 4'b0111)
      $display("FAIL adds_ovf got r1=%h nzcv=%b want r1=0 nzcv=0111", dut.regs[1], dut.nzcv);
    else passed++;
    step(32'hE3520007);
    checks++;
    if (dut.nzcv !== 4'b0110) $display("FAIL cmp_eq got %b want %b", dut.nzcv, 4'b0110); else passed++;
  endtask

  task automatic test_branch();
    apply_reset();
    for (int i = 0; i < 8; i++) step(NOP);
    checks++;
    if (PC !== 32'h20) $display("FAIL nop_walk got %h want %h", PC, 32'h20); else passed++;
    step(32'hEAFFFFFE);
    step(32'hEAFFFFFE);
    step(32'hEAFFFFFE);
    checks++;
    if (PC !== 32'h20) $display("FAIL self_branch got %h want %h", PC, 32'h20); else passed++;
    step(32'hEA000010);
    checks++;
    if (PC !== 32'h68) $display("FAIL fwd_branch got %h want %h", PC, 32'h68); else passed++;
    step(32'hEB000001);
    checks++;
    if (PC !== 32'h74 || dut.regs[14] !== 32'h6C)
      $display("FAIL bl got pc=%h lr=%h want pc=74 lr=6c", PC, dut.regs[14]);
    else passed++;
    step(32'hEAFFFFFC);
    checks++;
    if (PC !== 32'h6C) $display("FAIL back_branch got %h want %h", PC, 32'h6C); else passed++;
    step(32'hE8BD0001);
    step(32'hEE000000);
    checks++;
    if (PC !== 32'h74 || dut.regs[0] !== 32'd0)
      $display("FAIL other_class got pc=%h r0=%h want pc=74 r0=0", PC, dut.regs[0]);
    else passed++;
  endtask

  task automatic test_cond();
    logic [31:0] exp_r4;
    apply_reset();
    step(32'hE3A02007);
    step(32'hE3520007);
    step(32'h13A04001);
`ifdef CPU_CORE_COND_EXEC_EN
    exp_r4 = 32'd0;
`else
    exp_r4 = 32'd1;
`endif
    checks++;
    if (dut.regs[4] !== exp_r4) $display("FAIL cond_ne got %h want %h", dut.regs[4], exp_r4); else passed++;
    checks++;
    if (PC !== 32'hC) $display("FAIL cond_pc got %h want %h", PC, 32'hC); else passed++;
    step(32'h03A04002);
    checks++;
    if (dut.regs[4] !== 32'd2) $display("FAIL cond_eq got %h want %h", dut.regs[4], 32'd2); else passed++;
  endtask

  task automatic test_reset_suppress();
    step(32'hE5802008);
    checks++;
    if (dut.dmem[2] !== 32'd7) $display("FAIL str_pre got %h want %h", dut.dmem[2], 32'd7); else passed++;
    step(32'hE3A02055);
    @(negedge clk);
    inst = 32'hE5802008;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dut.dmem[2] !== 32'd7) $display("FAIL str_suppressed got %h want %h", dut.dmem[2], 32'd7); else passed++;
    checks++;
    if (dut.dmem[10'h280] !== 32'd7 || dut.dmem[1] !== 32'd14)
      $display("FAIL dmem_kept got %h/%h want 7/e", dut.dmem[10'h280], dut.dmem[1]);
    else passed++;
    inst = NOP;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dp();
    test_shift();
    test_r15();
    test_ldr_str();
    test_flags();
    test_branch();
    test_cond();
    test_reset_suppress();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
